// File: rtl/csr_seq_pkg.sv
// rtl/csr_seq_pkg.sv - shared CSR addresses, op codes and sequencer states
package csr_seq_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    typedef enum logic [1:0] {
        OP_RO = 2'b00,
        OP_RW = 2'b01,
        OP_RS = 2'b10,
        OP_RC = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EX_RD    = 3'd1,
        ST_EX_WR    = 3'd2,
        ST_TR_RD    = 3'd3,
        ST_TR_EPC   = 3'd4,
        ST_TR_CAUSE = 3'd5,
        ST_TR_STAT  = 3'd6
    } state_e;

endpackage

// File: rtl/csr_alu.sv
// rtl/csr_alu.sv - combinational RW/RS/RC new-value and write-enable decision
module csr_alu
    import csr_seq_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] old,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] result,
    output logic              wen
);

    // Set/clear with a zero mask must not write, so side-effecting CSRs stay untouched.
    always_comb begin
        result = old;
        wen    = 1'b0;
        case (csr_op_e'(op))
            OP_RW: begin
                result = wdata;
                wen    = 1'b1;
            end
            OP_RS: begin
                result = old | wdata;
                wen    = |wdata;
            end
            OP_RC: begin
                result = old & ~wdata;
                wen    = |wdata;
            end
            default: begin
                result = old;
                wen    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_seq.sv
// rtl/csr_seq.sv - CSR access and trap-entry sequencer in front of a CSR file
module csr_seq
    import csr_seq_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ex_req,
    input  logic [1:0]        i_ex_op,
    input  logic [ADDR_W-1:0] i_ex_addr,
    input  logic [DATA_W-1:0] i_ex_wdata,
    output logic              o_ex_ack,
    output logic [DATA_W-1:0] o_ex_rdata,
    input  logic              i_trap_req,
    input  logic [DATA_W-1:0] i_trap_pc,
    input  logic [DATA_W-1:0] i_trap_cause,
    output logic              o_trap_ack,
    output logic              o_csr_ren,
    output logic              o_csr_wen,
    output logic [ADDR_W-1:0] o_csr_addr,
    output logic [DATA_W-1:0] o_csr_wdata,
    input  logic [DATA_W-1:0] i_csr_rdata,
    output logic              o_busy
);

    state_e            state, next;
    logic [DATA_W-1:0] old_val;
    logic              capture;
    logic [DATA_W-1:0] alu_result;
    logic              alu_wen;
    logic [DATA_W-1:0] status_new;

    csr_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (i_ex_op),
        .old    (old_val),
        .wdata  (i_ex_wdata),
        .result (alu_result),
        .wen    (alu_wen)
    );

    // Trap entry stacks MIE into MPIE, masks interrupts and records M-mode as previous privilege.
    always_comb begin
        status_new                      = old_val;
        status_new[MSTATUS_MPIE]        = old_val[MSTATUS_MIE];
        status_new[MSTATUS_MIE]         = 1'b0;
        status_new[MSTATUS_MPP+1 -: 2]  = 2'b11;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            old_val <= '0;
        end else begin
            state <= next;
            if (capture) old_val <= i_csr_rdata;
        end
    end

    always_comb begin
        next        = state;
        capture     = 1'b0;
        o_csr_ren   = 1'b0;
        o_csr_wen   = 1'b0;
        o_csr_addr  = '0;
        o_csr_wdata = '0;
        o_ex_ack    = 1'b0;
        o_ex_rdata  = '0;
        o_trap_ack  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_trap_req)    next = ST_TR_RD;
                else if (i_ex_req) next = ST_EX_RD;
            end
            ST_EX_RD: begin
                o_csr_ren  = 1'b1;
                o_csr_addr = i_ex_addr;
                capture    = 1'b1;
                next       = ST_EX_WR;
            end
            ST_EX_WR: begin
                o_csr_addr  = i_ex_addr;
                o_csr_wdata = alu_result;
                o_csr_wen   = alu_wen;
                o_ex_ack    = 1'b1;
                o_ex_rdata  = old_val;
                next        = ST_IDLE;
            end
            ST_TR_RD: begin
                o_csr_ren  = 1'b1;
                o_csr_addr = ADDR_W'(CSR_MSTATUS);
                capture    = 1'b1;
                next       = ST_TR_EPC;
            end
            ST_TR_EPC: begin
                o_csr_wen   = 1'b1;
                o_csr_addr  = ADDR_W'(CSR_MEPC);
                o_csr_wdata = i_trap_pc;
                next        = ST_TR_CAUSE;
            end
            ST_TR_CAUSE: begin
                o_csr_wen   = 1'b1;
                o_csr_addr  = ADDR_W'(CSR_MCAUSE);
                o_csr_wdata = i_trap_cause;
                next        = ST_TR_STAT;
            end
            ST_TR_STAT: begin
                o_csr_wen   = 1'b1;
                o_csr_addr  = ADDR_W'(CSR_MSTATUS);
                o_csr_wdata = status_new;
                o_trap_ack  = 1'b1;
                next        = ST_IDLE;
            end
            default: next = ST_IDLE;
        endcase
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_csr_seq.sv
// tb/tb_csr_seq.sv - randomized self-checking bench for csr_seq with a transaction-level model
module tb_csr_seq;

    localparam int VW = 5 + 12 + 64 + 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_ex_req = 1'b0;
    logic [1:0]  i_ex_op = 2'b00;
    logic [11:0] i_ex_addr = '0;
    logic [63:0] i_ex_wdata = '0;
    logic        o_ex_ack;
    logic [63:0] o_ex_rdata;
    logic        i_trap_req = 1'b0;
    logic [63:0] i_trap_pc = '0;
    logic [63:0] i_trap_cause = '0;
    logic        o_trap_ack;
    logic        o_csr_ren;
    logic        o_csr_wen;
    logic [11:0] o_csr_addr;
    logic [63:0] o_csr_wdata;
    logic [63:0] i_csr_rdata;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    bit   [63:0] mem     [0:4095];
    bit   [63:0] ref_mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [63:0] pl_val = '0;
    logic [11:0] addrs [5] = '{12'h300, 12'h341, 12'h342, 12'h305, 12'h340};

    csr_seq #(.DATA_W(64), .ADDR_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ex_req     (i_ex_req),
        .i_ex_op      (i_ex_op),
        .i_ex_addr    (i_ex_addr),
        .i_ex_wdata   (i_ex_wdata),
        .o_ex_ack     (o_ex_ack),
        .o_ex_rdata   (o_ex_rdata),
        .i_trap_req   (i_trap_req),
        .i_trap_pc    (i_trap_pc),
        .i_trap_cause (i_trap_cause),
        .o_trap_ack   (o_trap_ack),
        .o_csr_ren    (o_csr_ren),
        .o_csr_wen    (o_csr_wen),
        .o_csr_addr   (o_csr_addr),
        .o_csr_wdata  (o_csr_wdata),
        .i_csr_rdata  (i_csr_rdata),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    // CSR file seen by the DUT: combinational read, write on the rising edge.
    assign i_csr_rdata = mem[o_csr_addr];
    always @(posedge clk) begin
        if (pl_en)          mem[pl_addr]    <= pl_val;
        else if (o_csr_wen) mem[o_csr_addr] <= o_csr_wdata;
    end

    typedef struct {
        logic [VW-1:0] val;
        logic [VW-1:0] mask;
        bit            wr;
        logic [11:0]   waddr;
        logic [63:0]   wval;
    } exp_t;

    exp_t q[$];

    function automatic exp_t mk(bit ren, bit wen, bit eack, bit tack,
                                logic [11:0] a, logic [63:0] wd, logic [63:0] rd);
        exp_t e;
        e.val   = {1'b1, ren, wen, eack, tack, a, wd, rd};
        e.mask  = {5'h1f, {12{ren | wen}}, {64{wen}}, {64{eack}}};
        e.wr    = wen;
        e.waddr = a;
        e.wval  = wd;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.val   = '0;
        e.mask  = '1;
        e.wr    = 1'b0;
        e.waddr = '0;
        e.wval  = '0;
        return e;
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {o_busy, o_csr_ren, o_csr_wen, o_ex_ack, o_trap_ack, o_csr_addr, o_csr_wdata, o_ex_rdata};
    endfunction

    // Per-cycle compare: an idle cycle arbitrates the requests it sees into a list of expected cycles.
    initial begin : cmp
        exp_t          e;
        logic [63:0]   old;
        logic [63:0]   nv;
        bit            we;
        logic [VW-1:0] act;
        forever begin
            @(negedge clk);
            if (pl_en) ref_mem[pl_addr] = pl_val;
            if (rst) begin
                q.delete();
                e = idle_exp();
            end else if (q.size() == 0) begin
                e = idle_exp();
                if (i_trap_req) begin
                    old = ref_mem[12'h300];
                    nv = old;
                    nv[7] = old[3];
                    nv[3] = 1'b0;
                    nv[12:11] = 2'b11;
                    q.push_back(mk(1, 0, 0, 0, 12'h300, 64'h0, 64'h0));
                    q.push_back(mk(0, 1, 0, 0, 12'h341, i_trap_pc, 64'h0));
                    q.push_back(mk(0, 1, 0, 0, 12'h342, i_trap_cause, 64'h0));
                    q.push_back(mk(0, 1, 0, 1, 12'h300, nv, 64'h0));
                end else if (i_ex_req) begin
                    old = ref_mem[i_ex_addr];
                    case (i_ex_op)
                        2'b01:   begin nv = i_ex_wdata;         we = 1'b1;             end
                        2'b10:   begin nv = old | i_ex_wdata;   we = (i_ex_wdata != 0); end
                        2'b11:   begin nv = old & ~i_ex_wdata;  we = (i_ex_wdata != 0); end
                        default: begin nv = old;                we = 1'b0;             end
                    endcase
                    q.push_back(mk(1, 0, 0, 0, i_ex_addr, 64'h0, 64'h0));
                    q.push_back(mk(0, we, 1, 0, i_ex_addr, nv, old));
                end
            end else begin
                e = q.pop_front();
            end
            act = act_vec();
            checks++;
            if ((act & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got %h want %h mask %h", $time, act, e.val, e.mask);
            end
            if (e.wr) ref_mem[e.waddr] = e.wval;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] v);
        pl_addr = a;
        pl_val  = v;
        pl_en   = 1'b1;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic wait_ack(input bit trap, input string name, input int want_lat,
                            output logic [63:0] rd);
        int lat;
        lat = -1;
        rd  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trap ? o_trap_ack : o_ex_ack) begin
                lat = i;
                rd  = o_ex_rdata;
                break;
            end
        end
        checks++;
        if (lat != want_lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, want_lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd);
        i_ex_op    = op;
        i_ex_addr  = a;
        i_ex_wdata = wd;
        i_ex_req   = 1'b1;
    endtask

    task automatic set_trap(input logic [63:0] pc, input logic [63:0] cause);
        i_trap_pc    = pc;
        i_trap_cause = cause;
        i_trap_req   = 1'b1;
    endtask

    task automatic rand_ex();
        logic [63:0] wd;
        wd = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
        set_ex(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 4)], wd);
    endtask

    initial begin : drive
        logic [63:0] rd;
        bit          b2b;
        int          kind;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {83'h0, act_vec()}, 64'h0);
        rst = 1'b0;

        preload(12'h300, 64'h1800);
        set_ex(2'b01, 12'h300, 64'h8);
        wait_ack(0, "rw_lat", 2, rd);
        i_ex_req = 1'b0;
        chk("rw_rdata", rd, 64'h1800);
        chk("rw_write", mem[12'h300], 64'h8);

        preload(12'h305, 64'h55);
        set_ex(2'b10, 12'h305, 64'h0);
        wait_ack(0, "rs0_lat", 2, rd);
        i_ex_req = 1'b0;
        chk("rs0_rdata", rd, 64'h55);
        chk("rs0_nowrite", mem[12'h305], 64'h55);

        preload(12'h300, 64'h1808);
        set_ex(2'b11, 12'h300, 64'h1000);
        wait_ack(0, "rc_lat", 2, rd);
        chk("rc_write", mem[12'h300], 64'h0808);
        set_ex(2'b00, 12'h300, 64'hffff);
        wait_ack(0, "b2b_ro_lat", 2, rd);
        i_ex_req = 1'b0;
        chk("ro_rdata", rd, 64'h0808);

        preload(12'h300, 64'h1808);
        set_trap(64'h80000010, 64'h2);
        wait_ack(1, "trap_lat", 4, rd);
        i_trap_req = 1'b0;
        chk("trap_mepc", mem[12'h341], 64'h80000010);
        chk("trap_mcause", mem[12'h342], 64'h2);
        chk("trap_mstatus", mem[12'h300], 64'h1880);

        set_trap(64'h4000, 64'h5);
        set_ex(2'b01, 12'h340, 64'h77);
        wait_ack(1, "both_trap_lat", 4, rd);
        i_trap_req = 1'b0;
        wait_ack(0, "both_ex_lat", 2, rd);
        i_ex_req = 1'b0;
        chk("both_mscratch", mem[12'h340], 64'h77);

        set_ex(2'b10, 12'h340, 64'h100);
        @(posedge clk);
        #1;
        set_trap(64'h5000, 64'h3);
        wait_ack(0, "mid_ex_lat", 1, rd);
        i_ex_req = 1'b0;
        wait_ack(1, "mid_trap_lat", 4, rd);
        i_trap_req = 1'b0;
        chk("mid_mscratch", mem[12'h340], 64'h177);

        preload(12'h300, 64'h1808);
        preload(12'h342, 64'h2);
        set_trap(64'h1234, 64'h7);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        i_trap_req = 1'b0;
        #1;
        chk("async_reset_outputs", {83'h0, act_vec()}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_no_cause", mem[12'h342], 64'h2);
        chk("reset_mstatus_kept", mem[12'h300], 64'h1808);
        set_trap(64'h1234, 64'h7);
        wait_ack(1, "retrap_lat", 4, rd);
        i_trap_req = 1'b0;
        chk("retrap_cause", mem[12'h342], 64'h7);
        chk("retrap_mstatus", mem[12'h300], 64'h1880);

        b2b = 1'b0;
        for (int n = 0; n < 150; n++) begin
            kind = b2b ? 0 : $urandom_range(0, 9);
            if (!b2b) begin
                i_ex_req   = 1'b0;
                i_trap_req = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            b2b = 1'b0;
            if (kind <= 5) begin
                rand_ex();
                wait_ack(0, "rnd_ex_lat", 2, rd);
                b2b = ($urandom_range(0, 1) == 1);
            end else if (kind <= 7) begin
                set_trap({$urandom, $urandom}, 64'($urandom_range(0, 15)));
                wait_ack(1, "rnd_trap_lat", 4, rd);
            end else if (kind == 8) begin
                rand_ex();
                set_trap({$urandom, $urandom}, 64'($urandom_range(0, 15)));
                wait_ack(1, "rnd_both_trap_lat", 4, rd);
                i_trap_req = 1'b0;
                wait_ack(0, "rnd_both_ex_lat", 2, rd);
            end else begin
                rand_ex();
                @(posedge clk);
                #1;
                set_trap({$urandom, $urandom}, 64'($urandom_range(0, 15)));
                wait_ack(0, "rnd_mid_ex_lat", 1, rd);
                i_ex_req = 1'b0;
                wait_ack(1, "rnd_mid_trap_lat", 4, rd);
            end
        end
        i_ex_req   = 1'b0;
        i_trap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
